stream_serializer: RTL and testbench

//  Wide-to-narrow converter on the valid/ready streaming interface.
//  - Accepts one RATIO*WIDTH-bit word upstream.
//  - Emits RATIO beats of WIDTH bits downstream, least-significant slice first.
//  - Flags the final beat with down_last.
//  - Sits between a wide datapath stage and a narrow link or pipeline.
//  - Supports full throughput: a new word can load on the last beat's handshake, so there is no bubble.

---
 rtl/stream_serializer_pkg.sv | 4 +
 rtl/stream_serializer.sv | 67 ++++++
 tb/tb_stream_serializer.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/stream_serializer_pkg.sv
// stream_serializer_pkg: shared types for the wide-to-narrow stream serializer.
package stream_serializer_pkg;
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
endpackage

// File: rtl/stream_serializer.sv
// stream_serializer: splits one RATIO*WIDTH-bit word into RATIO narrow beats, LSB slice first, with no bubble between words.
module stream_serializer
    import stream_serializer_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int RATIO = 4
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [WIDTH*RATIO-1:0]   up_data,
    input  logic                     up_valid,
    output logic                     up_ready,
    output logic [WIDTH-1:0]         down_data,
    output logic                     down_valid,
    output logic                     down_last,
    input  logic                     down_ready
);
    localparam int CNT_W = $clog2(RATIO);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(RATIO - 1);

    if (RATIO < 2) begin : g_ratio_check
        $fatal(1, "stream_serializer: RATIO must be >= 2");
    end

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [WIDTH*RATIO-1:0] sreg_q, sreg_d;
    logic                   on_last, up_fire, dn_fire;

    // Upstream may reload on the final beat's handshake, which keeps the link saturated.
    assign up_ready   = state_q == IDLE || (down_ready && cnt_q == LAST_BEAT);
    assign down_valid = state_q == BUSY;
    assign down_last  = on_last;
    assign down_data  = sreg_q[WIDTH-1:0];

    always_comb begin
        on_last = state_q == BUSY && cnt_q == LAST_BEAT;
        up_fire = up_valid && up_ready;
        dn_fire = state_q == BUSY && down_ready;
        state_d = state_q;
        cnt_d   = cnt_q;
        sreg_d  = sreg_q;
        if (up_fire) begin
            state_d = BUSY;
            cnt_d   = '0;
            sreg_d  = up_data;
        end else if (dn_fire && !on_last) begin
            cnt_d   = cnt_q + CNT_W'(1);
            sreg_d  = sreg_q >> WIDTH;
        end else if (dn_fire) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sreg_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sreg_q  <= sreg_d;
        end
    end
endmodule

// File: tb/tb_stream_serializer.sv
// tb_stream_serializer: directed scenarios plus a randomized run against a beat-queue reference model.
module tb_stream_serializer;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] up_data = '0;
    logic        up_valid = 1'b0;
    logic        up_ready;
    logic [7:0]  down_data;
    logic        down_valid;
    logic        down_last;
    logic        down_ready = 1'b0;
    int          total = 0;
    int          bad = 0;

    stream_serializer #(.WIDTH(8), .RATIO(4)) dut (
        .clock(clock), .reset_n(reset_n),
        .up_data(up_data), .up_valid(up_valid), .up_ready(up_ready),
        .down_data(down_data), .down_valid(down_valid), .down_last(down_last),
        .down_ready(down_ready)
    );

    always #5 clock = ~clock;

    function automatic logic [7:0] slice(input logic [31:0] w, input int i);
        return 8'((w >> (8 * i)) & 32'hFF);
    endfunction

    task automatic test_reset();
        #1;
        total += 4;
        if (down_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", down_valid); end
        if (down_last !== 1'b0) begin bad++; $display("FAIL reset_last got=%b want=0", down_last); end
        if (down_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", down_data); end
        if (up_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", up_ready); end
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_idle();
        up_valid = 1'b0;
        down_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            total += 2;
            if (down_valid !== 1'b0) begin bad++; $display("FAIL idle_valid cyc=%0d got=%b want=0", i, down_valid); end
            if (up_ready !== 1'b1) begin bad++; $display("FAIL idle_ready cyc=%0d got=%b want=1", i, up_ready); end
            @(negedge clock);
        end
    endtask

    task automatic test_single();
        logic [31:0] w = 32'h44332211;
        down_ready = 1'b1;
        up_data = w;
        up_valid = 1'b1;
        @(negedge clock);
        up_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            total += 4;
            if (down_valid !== 1'b1) begin bad++; $display("FAIL single_valid beat=%0d got=%b want=1", i, down_valid); end
            if (down_data !== slice(w, i)) begin bad++; $display("FAIL single_data beat=%0d got=%h want=%h", i, down_data, slice(w, i)); end
            if (down_last !== (i == 3)) begin bad++; $display("FAIL single_last beat=%0d got=%b want=%b", i, down_last, i == 3); end
            if (up_ready !== (i == 3)) begin bad++; $display("FAIL single_ready beat=%0d got=%b want=%b", i, up_ready, i == 3); end
            @(negedge clock);
        end
        #1;
        total += 2;
        if (down_valid !== 1'b0) begin bad++; $display("FAIL single_done_valid got=%b want=0", down_valid); end
        if (up_ready !== 1'b1) begin bad++; $display("FAIL single_done_ready got=%b want=1", up_ready); end
        @(negedge clock);
    endtask

    task automatic test_back_to_back();
        logic [63:0] ws = 64'h88776655_44332211;
        down_ready = 1'b1;
        up_data = ws[31:0];
        up_valid = 1'b1;
        @(negedge clock);
        up_data = ws[63:32];
        for (int i = 0; i < 8; i++) begin
            #1;
            total += 3;
            if (down_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid beat=%0d got=%b want=1", i, down_valid); end
            if (down_data !== 8'((ws >> (8 * i)) & 64'hFF)) begin bad++; $display("FAIL b2b_data beat=%0d got=%h want=%h", i, down_data, 8'((ws >> (8 * i)) & 64'hFF)); end
            if (down_last !== (i == 3 || i == 7)) begin bad++; $display("FAIL b2b_last beat=%0d got=%b want=%b", i, down_last, i == 3 || i == 7); end
            @(negedge clock);
            if (i == 3) up_valid = 1'b0;
        end
        #1;
        total++;
        if (down_valid !== 1'b0) begin bad++; $display("FAIL b2b_done_valid got=%b want=0", down_valid); end
        @(negedge clock);
    endtask

    task automatic test_stall();
        down_ready = 1'b1;
        up_data = 32'h44332211;
        up_valid = 1'b1;
        @(negedge clock);
        up_data = 32'hA5A5A5A5;
        @(negedge clock);
        down_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            total += 3;
            if (down_data !== 8'h22 || down_valid !== 1'b1) begin bad++; $display("FAIL stall_hold cyc=%0d got=%h/%b want=22/1", i, down_data, down_valid); end
            if (down_last !== 1'b0) begin bad++; $display("FAIL stall_last cyc=%0d got=%b want=0", i, down_last); end
            if (up_ready !== 1'b0) begin bad++; $display("FAIL stall_ready cyc=%0d got=%b want=0", i, up_ready); end
            @(negedge clock);
        end
        up_valid = 1'b0;
        down_ready = 1'b1;
        #1;
        total++;
        if (down_data !== 8'h22) begin bad++; $display("FAIL stall_release got=%h want=22", down_data); end
        @(negedge clock);
        #1;
        total++;
        if (down_data !== 8'h33 || down_valid !== 1'b1) begin bad++; $display("FAIL stall_next got=%h/%b want=33/1", down_data, down_valid); end
        repeat (3) @(negedge clock);
    endtask

    task automatic test_mid_reset();
        logic [31:0] w = 32'hDDCCBBAA;
        down_ready = 1'b1;
        up_data = 32'h44332211;
        up_valid = 1'b1;
        @(negedge clock);
        up_valid = 1'b0;
        repeat (2) @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        total += 3;
        if (down_valid !== 1'b0) begin bad++; $display("FAIL mreset_valid got=%b want=0", down_valid); end
        if (down_data !== 8'h00) begin bad++; $display("FAIL mreset_data got=%h want=00", down_data); end
        if (up_ready !== 1'b1) begin bad++; $display("FAIL mreset_ready got=%b want=1", up_ready); end
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        total++;
        if (down_valid !== 1'b0) begin bad++; $display("FAIL mreset_after got=%b want=0", down_valid); end
        @(negedge clock);
        up_data = w;
        up_valid = 1'b1;
        @(negedge clock);
        up_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++;
            if (down_valid !== 1'b1 || down_data !== slice(w, i)) begin bad++; $display("FAIL mreset_beat beat=%0d got=%h/%b want=%h/1", i, down_data, down_valid, slice(w, i)); end
            @(negedge clock);
        end
    endtask

    task automatic test_random();
        logic [7:0] q_data[$];
        bit         q_last[$];
        int         sent = 0;
        int         done = 0;
        int         cycles = 0;
        bit         exp_busy, exp_ready, fire_up, fire_dn;
        up_valid = 1'b0;
        while ((sent < 10000 || q_data.size() != 0) && cycles < 90000) begin
            if (!up_valid && sent < 10000) begin
                up_valid = $urandom_range(0, 3) != 0;
                up_data = $urandom;
            end
            down_ready = $urandom_range(0, 9) != 0;
            #1;
            exp_busy = q_data.size() != 0;
            exp_ready = !exp_busy || (down_ready && q_data.size() == 1);
            total += 2;
            if (down_valid !== exp_busy) begin bad++; $display("FAIL rand_valid cyc=%0d got=%b want=%b", cycles, down_valid, exp_busy); end
            if (up_ready !== exp_ready) begin bad++; $display("FAIL rand_ready cyc=%0d got=%b want=%b", cycles, up_ready, exp_ready); end
            if (exp_busy) begin
                total += 2;
                if (down_data !== q_data[0]) begin bad++; $display("FAIL rand_data cyc=%0d got=%h want=%h", cycles, down_data, q_data[0]); end
                if (down_last !== q_last[0]) begin bad++; $display("FAIL rand_last cyc=%0d got=%b want=%b", cycles, down_last, q_last[0]); end
            end
            fire_dn = exp_busy && down_ready;
            fire_up = up_valid && exp_ready;
            if (fire_dn) begin
                if (q_last[0]) done++;
                void'(q_data.pop_front());
                void'(q_last.pop_front());
            end
            if (fire_up) begin
                for (int i = 0; i < 4; i++) begin
                    q_data.push_back(slice(up_data, i));
                    q_last.push_back(i == 3);
                end
                sent++;
            end
            @(negedge clock);
            if (fire_up) up_valid = 1'b0;
            cycles++;
        end
        up_valid = 1'b0;
        total++;
        if (done !== 10000) begin bad++; $display("FAIL rand_words got=%0d want=10000 cycles=%0d", done, cycles); end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_single();
        test_back_to_back();
        test_stall();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
